// File: rtl/fir_pkg.sv
// Shared types and helpers for the complex FIR MAC engine.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_MAC   = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    // Elaboration-time ceiling log2. Any value <= 1 returns 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/complex_fir_mac_if.sv
// Coefficient stream, sample handshake and result bus of the complex FIR MAC.
interface complex_fir_mac_if #(
    parameter int TAPS        = 16,
    parameter int DATA_WIDTH  = 24,
    parameter int COEFF_WIDTH = 8
) ();
    localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + 1 + fir_pkg::clog2(TAPS);

    logic                          coeffLoadStart;
    logic                          coeffValid;
    logic signed [COEFF_WIDTH-1:0] coeffInRe;
    logic signed [COEFF_WIDTH-1:0] coeffInIm;
    logic                          flushData;
    logic                          inValid;
    logic                          inReady;
    logic signed [DATA_WIDTH-1:0]  dataInRe;
    logic signed [DATA_WIDTH-1:0]  dataInIm;
    logic                          outValid;
    logic signed [ACC_WIDTH-1:0]   dataOutRe;
    logic signed [ACC_WIDTH-1:0]   dataOutIm;
    logic                          busy;

    modport master (
        output coeffLoadStart, coeffValid, coeffInRe, coeffInIm,
        output flushData, inValid, dataInRe, dataInIm,
        input  inReady, outValid, dataOutRe, dataOutIm, busy
    );

    modport slave (
        input  coeffLoadStart, coeffValid, coeffInRe, coeffInIm,
        input  flushData, inValid, dataInRe, dataInIm,
        output inReady, outValid, dataOutRe, dataOutIm, busy
    );

endinterface

// File: rtl/complex_mac.sv
// Combinational complex multiply x*h (or x*conj(h)), exact at DATA_WIDTH+COEFF_WIDTH+1 bits.
module complex_mac #(
    parameter int DATA_WIDTH  = 24,
    parameter int COEFF_WIDTH = 8,
    parameter int CONJ_MODE   = 0
) (
    input  logic signed [DATA_WIDTH-1:0]          x_re,
    input  logic signed [DATA_WIDTH-1:0]          x_im,
    input  logic signed [COEFF_WIDTH-1:0]         h_re,
    input  logic signed [COEFF_WIDTH-1:0]         h_im,
    output logic signed [DATA_WIDTH+COEFF_WIDTH:0] prod_re,
    output logic signed [DATA_WIDTH+COEFF_WIDTH:0] prod_im
);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH + 1;

    logic signed [PW-1:0] xr;
    logic signed [PW-1:0] xi;
    logic signed [PW-1:0] hr;
    logic signed [PW-1:0] hi_ext;
    logic signed [PW-1:0] hi;

    assign xr     = {{(PW-DATA_WIDTH){x_re[DATA_WIDTH-1]}}, x_re};
    assign xi     = {{(PW-DATA_WIDTH){x_im[DATA_WIDTH-1]}}, x_im};
    assign hr     = {{(PW-COEFF_WIDTH){h_re[COEFF_WIDTH-1]}}, h_re};
    assign hi_ext = {{(PW-COEFF_WIDTH){h_im[COEFF_WIDTH-1]}}, h_im};

    // Negate after widening so the most negative coefficient does not wrap.
    assign hi = (CONJ_MODE != 0) ? -hi_ext : hi_ext;

    assign prod_re = xr * hr - xi * hi;
    assign prod_im = xr * hi + xi * hr;

endmodule

// File: rtl/complex_fir_mac.sv
// Complex FIR: loads TAPS coefficients, then one complex MAC per cycle per accepted sample.
//  state    | meaning
//  ST_LOAD  | collecting TAPS coefficient words, h[0] first
//  ST_READY | idle, accepts a sample or a delay-line flush
//  ST_MAC   | one tap per cycle, TAPS cycles
//  ST_DONE  | register accumulator to the output, pulse outValid
module complex_fir_mac
    import fir_pkg::*;
#(
    parameter int TAPS        = 16,
    parameter int DATA_WIDTH  = 24,
    parameter int COEFF_WIDTH = 8,
    parameter int CONJ_MODE   = 0
) (
    input logic              clock,
    input logic              resetN,
    complex_fir_mac_if.slave bus
);
    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 1 + clog2(TAPS);
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int CNT_W      = clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

    fir_state_e state;
    fir_state_e state_nxt;

    logic [CNT_W-1:0] coeff_cnt;
    logic [CNT_W-1:0] tap_idx;

    logic signed [COEFF_WIDTH-1:0] h_re [TAPS];
    logic signed [COEFF_WIDTH-1:0] h_im [TAPS];
    logic signed [DATA_WIDTH-1:0]  x_re [TAPS];
    logic signed [DATA_WIDTH-1:0]  x_im [TAPS];

    logic signed [ACC_WIDTH-1:0]  acc_re;
    logic signed [ACC_WIDTH-1:0]  acc_im;
    logic signed [ACC_WIDTH-1:0]  out_re;
    logic signed [ACC_WIDTH-1:0]  out_im;
    logic                         out_valid;
    logic signed [PROD_WIDTH-1:0] prod_re;
    logic signed [PROD_WIDTH-1:0] prod_im;

    logic cnt_clr;
    logic coeff_wr;
    logic accept;
    logic flush;
    logic mac_en;
    logic out_load;
    logic illegal;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        coeff_wr  = 1'b0;
        accept    = 1'b0;
        flush     = 1'b0;
        mac_en    = 1'b0;
        out_load  = 1'b0;
        illegal   = 1'b0;

        case (state)
            ST_LOAD: begin
                if (bus.coeffValid) begin
                    coeff_wr = 1'b1;
                    if (coeff_cnt == LAST_IDX) begin
                        state_nxt = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (bus.inValid) begin
                    accept    = 1'b1;
                    state_nxt = ST_MAC;
                end else if (bus.flushData) begin
                    flush = 1'b1;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (tap_idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_load  = 1'b1;
                state_nxt = ST_READY;
            end
            default: begin
                illegal   = 1'b1;
                state_nxt = ST_READY;
            end
        endcase

        // A reload overrides everything except the result already being emitted in DONE.
        if (bus.coeffLoadStart) begin
            state_nxt = ST_LOAD;
            cnt_clr   = 1'b1;
            coeff_wr  = 1'b0;
            accept    = 1'b0;
            flush     = 1'b0;
            mac_en    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            coeff_cnt <= '0;
            for (int i = 0; i < TAPS; i++) begin
                h_re[i] <= '0;
                h_im[i] <= '0;
            end
        end else begin
            if (cnt_clr) begin
                coeff_cnt <= '0;
            end else if (coeff_wr) begin
                coeff_cnt <= (coeff_cnt == LAST_IDX) ? '0 : coeff_cnt + 1'b1;
            end
            if (coeff_wr) begin
                h_re[coeff_cnt] <= bus.coeffInRe;
                h_im[coeff_cnt] <= bus.coeffInIm;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tap_idx   <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
            end
        end else if (illegal) begin
            tap_idx   <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
            end
        end else begin
            out_valid <= out_load;
            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    x_re[i] <= x_re[i-1];
                    x_im[i] <= x_im[i-1];
                end
                x_re[0] <= bus.dataInRe;
                x_im[0] <= bus.dataInIm;
                acc_re  <= '0;
                acc_im  <= '0;
                tap_idx <= '0;
            end else if (flush) begin
                for (int i = 0; i < TAPS; i++) begin
                    x_re[i] <= '0;
                    x_im[i] <= '0;
                end
            end
            if (mac_en) begin
                acc_re  <= acc_re + {{(ACC_WIDTH-PROD_WIDTH){prod_re[PROD_WIDTH-1]}}, prod_re};
                acc_im  <= acc_im + {{(ACC_WIDTH-PROD_WIDTH){prod_im[PROD_WIDTH-1]}}, prod_im};
                tap_idx <= (tap_idx == LAST_IDX) ? '0 : tap_idx + 1'b1;
            end
            if (out_load) begin
                out_re <= acc_re;
                out_im <= acc_im;
            end
        end
    end

    complex_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .CONJ_MODE  (CONJ_MODE)
    ) u_complex_mac (
        .x_re   (x_re[tap_idx]),
        .x_im   (x_im[tap_idx]),
        .h_re   (h_re[tap_idx]),
        .h_im   (h_im[tap_idx]),
        .prod_re(prod_re),
        .prod_im(prod_im)
    );

    assign bus.inReady   = (state == ST_READY) && !bus.coeffLoadStart;
    assign bus.busy      = (state != ST_READY);
    assign bus.outValid  = out_valid;
    assign bus.dataOutRe = out_re;
    assign bus.dataOutIm = out_im;

endmodule

// File: tb/tb_complex_fir_mac.sv
// Random and directed stimulus for complex_fir_mac against a plain-arithmetic convolution model.
module tb_complex_fir_mac;
    import fir_pkg::*;

    localparam int TAPS = 4;
    localparam int DW   = 24;
    localparam int CW   = 8;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    complex_fir_mac_if #(.TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus0 ();
    complex_fir_mac_if #(.TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus1 ();

    complex_fir_mac #(.TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .CONJ_MODE(0)) dut0 (
        .clock(clock), .resetN(resetN), .bus(bus0));
    complex_fir_mac #(.TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .CONJ_MODE(1)) dut1 (
        .clock(clock), .resetN(resetN), .bus(bus1));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: h as loaded, x newest-first, expected results in acceptance order.
    longint mh_re [TAPS];
    longint mh_im [TAPS];
    longint mx_re [TAPS];
    longint mx_im [TAPS];
    longint ld_re [TAPS];
    longint ld_im [TAPS];
    longint exp_re_q [$];
    longint exp_im_q [$];
    int     acc_cyc_q [$];
    longint last_re, last_im, last_exp_re, last_exp_im;
    int     n_acc, n_res, prev_acc_cyc;
    bit     b2b_mode = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd_s(input int w);
        longint v;
        v = longint'($urandom) & ((64'sd1 <<< w) - 1);
        if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    function automatic void model_accept(input longint re, input longint im);
        longint sr, si;
        for (int i = TAPS - 1; i > 0; i--) begin
            mx_re[i] = mx_re[i-1];
            mx_im[i] = mx_im[i-1];
        end
        mx_re[0] = re;
        mx_im[0] = im;
        sr = 0;
        si = 0;
        for (int k = 0; k < TAPS; k++) begin
            sr += mx_re[k] * mh_re[k] - mx_im[k] * mh_im[k];
            si += mx_re[k] * mh_im[k] + mx_im[k] * mh_re[k];
        end
        exp_re_q.push_back(sr);
        exp_im_q.push_back(si);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            mh_re[i] = 0; mh_im[i] = 0; mx_re[i] = 0; mx_im[i] = 0;
        end
        exp_re_q.delete();
        exp_im_q.delete();
        acc_cyc_q.delete();
    endfunction

    always @(negedge clock) begin
        if (resetN) begin
            if (bus0.inValid && bus0.inReady) begin
                if (b2b_mode && n_acc > 0) chk("b2b_gap", cyc + 1 - prev_acc_cyc, TAPS + 2);
                prev_acc_cyc = cyc + 1;
                n_acc++;
                model_accept(longint'(bus0.dataInRe), longint'(bus0.dataInIm));
                acc_cyc_q.push_back(cyc + 1);
            end
            if (bus0.outValid) begin
                n_res++;
                last_re = longint'(bus0.dataOutRe);
                last_im = longint'(bus0.dataOutIm);
                chk("out_expected", longint'(exp_re_q.size() > 0), 1);
                if (exp_re_q.size() > 0) begin
                    last_exp_re = exp_re_q.pop_front();
                    last_exp_im = exp_im_q.pop_front();
                    chk("out_re", last_re, last_exp_re);
                    chk("out_im", last_im, last_exp_im);
                    chk("latency", cyc - acc_cyc_q.pop_front(), TAPS + 1);
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_re_q.size() != 0 || bus0.busy) && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_idle"}, longint'(n < 500), 1);
    endtask

    task automatic load_coeffs(input bit do_start, input bit chk_ready);
        if (do_start) begin
            @(posedge clock); #1 bus0.coeffLoadStart = 1'b1;
            @(posedge clock); #1 bus0.coeffLoadStart = 1'b0;
        end
        for (int i = 0; i < TAPS; i++) begin
            bus0.coeffValid = 1'b1;
            bus0.coeffInRe  = ld_re[i][CW-1:0];
            bus0.coeffInIm  = ld_im[i][CW-1:0];
            @(posedge clock); #1;
            if (chk_ready) chk("ready_during_load", longint'(bus0.inReady), longint'(i == TAPS - 1));
        end
        bus0.coeffValid = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            mh_re[i] = ld_re[i];
            mh_im[i] = ld_im[i];
        end
    endtask

    task automatic send_sample(input longint re, input longint im);
        int n;
        n = 0;
        bus0.inValid  = 1'b1;
        bus0.dataInRe = re[DW-1:0];
        bus0.dataInIm = im[DW-1:0];
        @(negedge clock);
        while (!bus0.inReady && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("accepted", longint'(n < 500), 1);
        @(posedge clock); #1 bus0.inValid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, longint'(bus0.outValid), 0);
        chk({tag, "_out_re"}, longint'(bus0.dataOutRe), 0);
        chk({tag, "_out_im"}, longint'(bus0.dataOutIm), 0);
        chk({tag, "_in_ready"}, longint'(bus0.inReady), 0);
        chk({tag, "_busy"}, longint'(bus0.busy), 1);
        chk({tag, "_state"}, longint'(dut0.state), longint'(ST_LOAD));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, saved;
        bus0.coeffLoadStart = 0; bus0.coeffValid = 0; bus0.coeffInRe = 0; bus0.coeffInIm = 0;
        bus0.flushData = 0; bus0.inValid = 0; bus0.dataInRe = 0; bus0.dataInIm = 0;
        bus1.coeffLoadStart = 0; bus1.coeffValid = 0; bus1.coeffInRe = 0; bus1.coeffInIm = 0;
        bus1.flushData = 0; bus1.inValid = 0; bus1.dataInRe = 0; bus1.dataInIm = 0;
        model_clear();
        n_acc = 0;
        n_res = 0;

        repeat (2) @(posedge clock);
        #1 check_reset_outputs("reset");
        @(posedge clock); #1 resetN = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        chk("no_ready_before_load", longint'(bus0.inReady), 0);

        // Matched-filter instance: (3+4j) * conj(3+4j) = 25.
        @(posedge clock); #1 bus1.coeffLoadStart = 1'b1;
        @(posedge clock); #1 bus1.coeffLoadStart = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            bus1.coeffValid = 1'b1;
            bus1.coeffInRe  = (i == 0) ? 8'sd3 : 8'sd0;
            bus1.coeffInIm  = (i == 0) ? 8'sd4 : 8'sd0;
            @(posedge clock); #1;
        end
        bus1.coeffValid = 1'b0;
        bus1.inValid = 1'b1; bus1.dataInRe = 24'sd3; bus1.dataInIm = 24'sd4;
        n = 0;
        @(negedge clock);
        while (!bus1.inReady && n < 50) begin @(negedge clock); n++; end
        @(posedge clock); #1 bus1.inValid = 1'b0;
        n = 0;
        while (!bus1.outValid && n < 50) begin @(negedge clock); n++; end
        chk("conj_seen", longint'(n < 50), 1);
        chk("conj_re", longint'(bus1.dataOutRe), 25);
        chk("conj_im", longint'(bus1.dataOutIm), 0);

        // Impulse: outputs reproduce h[0..3].
        ld_re = '{1, -3, 0, 5};
        ld_im = '{2, 0, 1, -5};
        load_coeffs(1'b1, 1'b1);
        send_sample(1, 0);
        for (int i = 0; i < 3; i++) send_sample(0, 0);
        wait_idle("impulse");
        chk("impulse_last_re", last_re, 5);
        chk("impulse_last_im", last_im, -5);

        // Random coefficients and samples with random gaps.
        for (int i = 0; i < TAPS; i++) begin ld_re[i] = rnd_s(CW); ld_im[i] = rnd_s(CW); end
        load_coeffs(1'b1, 1'b0);
        for (int s = 0; s < 24; s++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            send_sample(rnd_s(DW), rnd_s(DW));
        end
        wait_idle("random");
        repeat (3) begin @(posedge clock); #1; end
        chk("hold_re", longint'(bus0.dataOutRe), last_exp_re);
        chk("hold_im", longint'(bus0.dataOutIm), last_exp_im);

        // Full scale: most negative samples and coefficients, full delay line.
        for (int i = 0; i < TAPS; i++) begin ld_re[i] = -128; ld_im[i] = -128; end
        load_coeffs(1'b1, 1'b0);
        for (int s = 0; s < TAPS; s++) send_sample(-(64'sd1 <<< (DW - 1)), -(64'sd1 <<< (DW - 1)));
        wait_idle("fullscale");
        chk("fullscale_re", last_re, 0);
        chk("fullscale_im", last_im, longint'(2 * TAPS) <<< (DW + CW - 2));

        // Back-to-back: inValid held for 60 cycles.
        n_acc = 0;
        n_res = 0;
        b2b_mode = 1'b1;
        @(posedge clock); #1;
        bus0.inValid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus0.dataInRe = rnd_s(DW); bus0.dataInIm = rnd_s(DW);
            @(posedge clock); #1;
        end
        bus0.inValid = 1'b0;
        wait_idle("b2b");
        b2b_mode = 1'b0;
        chk("b2b_accepts", n_acc, 10);
        chk("b2b_results", n_res, n_acc);

        // Reload in the third MAC cycle: result dropped, new h applied to retained x.
        send_sample(rnd_s(DW), rnd_s(DW));
        saved = n_res;
        @(posedge clock); #1;
        @(posedge clock); #1 bus0.coeffLoadStart = 1'b1;
        void'(exp_re_q.pop_back());
        void'(exp_im_q.pop_back());
        void'(acc_cyc_q.pop_back());
        @(posedge clock); #1 bus0.coeffLoadStart = 1'b0;
        for (int i = 0; i < TAPS; i++) begin ld_re[i] = rnd_s(CW); ld_im[i] = rnd_s(CW); end
        load_coeffs(1'b0, 1'b1);
        repeat (4) begin @(posedge clock); #1; end
        chk("abort_no_out", n_res, saved);
        send_sample(rnd_s(DW), rnd_s(DW));
        wait_idle("reload");

        // Flush keeps h and zeroes x.
        @(posedge clock); #1 bus0.flushData = 1'b1;
        @(posedge clock); #1 bus0.flushData = 1'b0;
        for (int i = 0; i < TAPS; i++) begin mx_re[i] = 0; mx_im[i] = 0; end
        send_sample(2, 0);
        wait_idle("flush");
        chk("flush_re", last_re, 2 * mh_re[0]);
        chk("flush_im", last_im, 2 * mh_im[0]);

        // Reset in the middle of a MAC.
        send_sample(rnd_s(DW), rnd_s(DW));
        @(posedge clock); #3 resetN = 1'b0;
        #1 check_reset_outputs("mid_mac_reset");
        model_clear();
        @(posedge clock); #1 resetN = 1'b1;
        repeat (6) begin @(posedge clock); #1; end
        chk("ready_after_reset", longint'(bus0.inReady), 0);
        for (int i = 0; i < TAPS; i++) begin ld_re[i] = rnd_s(CW); ld_im[i] = rnd_s(CW); end
        load_coeffs(1'b0, 1'b1);
        send_sample(rnd_s(DW), rnd_s(DW));
        wait_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_fir_mac.md
COMPLEX_FIR_MAC -- requirements
Module: complex_fir_mac

Interface
REQ-001 Parameter TAPS, default 16, number of complex coefficients (2..256).
REQ-002 Parameter DATA_WIDTH, default 24, signed width of each sample component.
REQ-003 Parameter COEFF_WIDTH, default 8, signed width of each coefficient component.
REQ-004 Parameter CONJ_MODE, default 0, 1 = multiply by conj(h) (matched filter), 0 = plain h.
REQ-005 Derived ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + 1 + clog2(TAPS), not overridable.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low: clock in 1, rising-edge clock; resetN in 1, asynchronous active-low reset.
REQ-007 coeffLoadStart in 1, one-cycle pulse that starts a coefficient reload.
REQ-008 coeffValid in 1; coeffInRe, coeffInIm in COEFF_WIDTH each: coefficient stream.
REQ-009 flushData in 1, pulse that zeroes the sample delay line.
REQ-010 inValid in 1, inReady out 1; dataInRe, dataInIm in DATA_WIDTH each: sample handshake.
REQ-011 outValid out 1; dataOutRe, dataOutIm out ACC_WIDTH each: result, valid for one cycle.
REQ-012 busy out 1, high in LOAD, MAC and DONE.

Function
REQ-013 States: LOAD, READY, MAC, DONE; the encoding SHALL be complete, and any illegal code SHALL go to READY with all datapath registers cleared.
REQ-014 In any state, coeffLoadStart SHALL move the FSM to LOAD and clear the coefficient counter.
- An in-progress MAC SHALL be aborted, with no outValid.
REQ-015 In LOAD, each coeffValid cycle SHALL write h[count] and increment count.
- h[0] is the first word.
- After the TAPS-th write, the FSM SHALL enter READY.
- coeffValid outside LOAD SHALL be ignored.
REQ-016 inReady SHALL equal (state==READY) and not coeffLoadStart; a sample is accepted on inValid and inReady.
REQ-017 On acceptance, the delay line SHALL shift one place, with x[0] = new sample.
- The complex accumulator SHALL clear, k SHALL clear, and the FSM SHALL go to MAC.
REQ-018 MAC SHALL perform one complex multiply-accumulate per cycle, acc += x[k]*h[k] (conj(h[k]) if CONJ_MODE).
- It SHALL run for exactly TAPS cycles, then go to DONE.
REQ-019 Complex product: Re = xr*hr - xi*hi, Im = xr*hi + xi*hr.
- For CONJ_MODE the hi sign SHALL be inverted.
- All arithmetic SHALL be signed at full ACC_WIDTH precision, with no rounding or saturation; overflow is impossible by construction.
REQ-020 In DONE, dataOut SHALL be registered from the accumulator and outValid SHALL be asserted for one cycle; the next state is READY.
- Latency from the acceptance edge to the outValid edge SHALL be TAPS+1 cycles.
- Peak throughput SHALL be one sample per TAPS+2 cycles.
REQ-021 dataOut SHALL hold its last value until the next DONE.
REQ-022 flushData SHALL be honoured only in READY, and only when no sample is accepted in the same cycle.
- It SHALL zero the delay line in one cycle and leave the coefficients intact.
REQ-023 With coeffLoadStart and inValid both asserted in READY, the load SHALL win and the sample SHALL NOT be accepted.
REQ-024 With coeffLoadStart asserted in DONE, the result SHALL still be output (outValid=1) and the next state SHALL be LOAD.

Reset
REQ-025 On resetN low, all of the following SHALL clear asynchronously:
- state = LOAD, counter = 0;
- all h and x = 0, accumulator = 0;
- outValid = 0, dataOutRe = dataOutIm = 0, inReady = 0, busy = 1.
REQ-026 Reset asserted mid-MAC SHALL discard the computation; after release, TAPS coefficients SHALL be required before inReady rises.

Structure
REQ-027 A shared package fir_pkg SHALL hold the state enumeration and the clog2 function.
REQ-028 A sub-module complex_mac SHALL implement one registered-free complex multiply with the conj option, instantiated once.

Verification
REQ-029 Impulse test: TAPS=4, h = (1+2j, -3+0j, 0+1j, 5-5j), one input sample 1+0j followed by three 0+0j samples -> outputs equal h[0..3] in order, each outValid exactly 5 cycles after its acceptance.
REQ-030 CONJ_MODE=1 test: h[0] = 3+4j, x = 3+4j, other taps 0 -> output 25+0j.
REQ-031 Full-scale test: all x = -2^(DATA_WIDTH-1)(1+j), all h = -2^(COEFF_WIDTH-1)(1+j), buffer full -> exact value with no wrap; Re = 0 and Im = 2*TAPS*2^(DATA_WIDTH+COEFF_WIDTH-2).
REQ-032 Reload mid-MAC test: coeffLoadStart in cycle 3 of MAC -> no outValid, inReady low until TAPS new coefficients are loaded, and the next result uses the new h and the retained x.
REQ-033 Reset and flush test: resetN pulsed during MAC -> all outputs 0 and state LOAD; separately, flushData in READY followed by one sample 2+0j -> output 2*h[0].
REQ-034 Back-to-back test: inValid held high -> exactly one acceptance per TAPS+2 cycles, and the sample count equals the result count.
